div_iter: RTL and testbench

Iterative radix-2 restoring divider for the execute stage, the divide counterpart of the two-stage Booth/Wallace multiplier and sharing its clock domain. It accepts one 32-bit signed or unsigned divide per request, produces a 32-bit quotient and a 32-bit remainder, and holds them until the pipeline acknowledges. One operation is in flight at a time. It occupies the DIV/MOD slot of the execute stage and stalls it via `div_ready`/`complete`.

---
 rtl/div_iter.sv | 114 +++++++++++
 tb/tb_div_iter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (32-bit signed/unsigned): one divide in flight,
// quotient/remainder held until acknowledged. Optional build macro: DIV_ZERO_FAST_EN.
module div_iter (
    input  logic        mul_clk,
    input  logic        resetn,
    input  logic        div_valid,
    input  logic        div_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        div_ready,
    input  logic        result_ack,
    output logic [31:0] s,
    output logic [31:0] r,
    output logic        complete
);

    typedef enum logic [2:0] {IDLE, ABS, ITER, FIX, DONE} state_t;

    state_t      stateReg, stateNext;
    logic [4:0]  cntReg;
    logic [31:0] aReg;       // raw dividend in ABS, then shift register: |x| out, quotient in
    logic [31:0] yAbsReg;    // raw divisor in ABS, then |y|
    logic [31:0] pReg;       // partial remainder; its 33rd bit is always 0 once stored
    logic [31:0] sReg, rReg;
    logic        signedReg, qSignReg, rSignReg;
    logic [31:0] absX, absY;
    logic [32:0] trial;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign absX  = (signedReg && aReg[31])    ? -aReg    : aReg;
    assign absY  = (signedReg && yAbsReg[31]) ? -yAbsReg : yAbsReg;
    assign trial = {pReg, aReg[31]} - {1'b0, yAbsReg};

    always_ff @(posedge mul_clk) begin
        if (!resetn) stateReg <= IDLE;
        else         stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (div_valid) stateNext = ABS;
`ifdef DIV_ZERO_FAST_EN
            ABS:  stateNext = (absY == 32'd0) ? FIX : ITER;
`else
            ABS:  stateNext = ITER;
`endif
            ITER: if (cntReg == 5'd31) stateNext = FIX;
            FIX:  stateNext = DONE;
            DONE: if (result_ack) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            cntReg    <= 5'd0;
            aReg      <= 32'd0;
            yAbsReg   <= 32'd0;
            pReg      <= 32'd0;
            sReg      <= 32'd0;
            rReg      <= 32'd0;
            signedReg <= 1'b0;
            qSignReg  <= 1'b0;
            rSignReg  <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (div_valid) begin
                        aReg      <= x;
                        yAbsReg   <= y;
                        signedReg <= div_signed;
                    end
                end
                ABS: begin
                    aReg     <= absX;
                    yAbsReg  <= absY;
                    pReg     <= 32'd0;
                    cntReg   <= 5'd0;
                    qSignReg <= signedReg & (aReg[31] ^ yAbsReg[31]);
                    rSignReg <= signedReg & aReg[31];
`ifdef DIV_ZERO_FAST_EN
                    // same values the full 32 iterations would leave behind
                    if (absY == 32'd0) begin
                        aReg <= 32'hFFFF_FFFF;
                        pReg <= absX;
                    end
`endif
                end
                ITER: begin
                    cntReg <= cntReg + 5'd1;
                    if (!trial[32]) begin
                        pReg <= trial[31:0];
                        aReg <= {aReg[30:0], 1'b1};
                    end else begin
                        pReg <= {pReg[30:0], aReg[31]};
                        aReg <= {aReg[30:0], 1'b0};
                    end
                end
                FIX: begin
                    sReg <= qSignReg ? -aReg : aReg;
                    rReg <= rSignReg ? -pReg : pReg;
                end
                default: ;
            endcase
        end
    end

    assign div_ready = (stateReg == IDLE);
    assign complete  = (stateReg == DONE);
    assign s         = sReg;
    assign r         = rReg;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed cases, reset mid-operation, back-to-back, random pairs.
module tb_div_iter;

    logic        mul_clk = 1'b0;
    logic        resetn;
    logic        div_valid, div_signed, result_ack;
    logic [31:0] x, y;
    logic        div_ready, complete;
    logic [31:0] s, r;

    typedef struct {
        logic [31:0] s;
        logic [31:0] r;
        int          lat;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastExp;
    int   compared = 0;
    int   mismatched = 0;
    int   cycleCnt = 0;
    int   lastAccept = 0;
    bit   haveLast = 0;

    div_iter dut (
        .mul_clk(mul_clk), .resetn(resetn), .div_valid(div_valid), .div_signed(div_signed),
        .x(x), .y(y), .div_ready(div_ready), .result_ack(result_ack),
        .s(s), .r(r), .complete(complete)
    );

    always #5 mul_clk = ~mul_clk;
    always @(posedge mul_clk) cycleCnt <= cycleCnt + 1;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expv);
        compared++;
        if (got !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic int zeroLat();
`ifdef DIV_ZERO_FAST_EN
        return 2;
`else
        return 34;
`endif
    endfunction

    function automatic exp_t model(input logic sgn, input logic [31:0] xv, input logic [31:0] yv);
        exp_t e;
        int   xi, yi;
        e.lat = 34;
        xi = xv;
        yi = yv;
        if (yv == 32'd0) begin
            e.s   = (sgn && xv[31]) ? 32'd1 : 32'hFFFF_FFFF;
            e.r   = xv;
            e.lat = zeroLat();
        end else if (!sgn) begin
            e.s = xv / yv;
            e.r = xv % yv;
        end else if (xv == 32'h8000_0000 && yv == 32'hFFFF_FFFF) begin
            e.s = 32'h8000_0000;
            e.r = 32'd0;
        end else begin
            e.s = xi / yi;
            e.r = xi % yi;
        end
        return e;
    endfunction

    // Drives a request until accepted and pushes its expected result.
    task automatic issue(input logic sgn, input logic [31:0] xv, input logic [31:0] yv, input exp_t e);
        bit rdy;
        int n;
        div_valid  = 1'b1;
        div_signed = sgn;
        x          = xv;
        y          = yv;
        n          = 0;
        do begin
            rdy = div_ready;
            @(posedge mul_clk); #1;
            n++;
        end while (!rdy && n < 200);
        checkVal("accept_timeout", 32'(rdy), 32'd1);
        if (haveLast) checkVal("issue_interval_ge35", 32'((cycleCnt - lastAccept) >= 35), 32'd1);
        lastAccept = cycleCnt;
        haveLast   = 1;
        sbQ.push_back(e);
        div_valid  = 1'b0;
        div_signed = $urandom_range(0, 1);
        x          = $urandom;
        y          = $urandom;
    endtask

    // Waits for complete (optionally with ignored ack/valid noise), then pops and compares.
    task automatic waitDone(input bit noise);
        int n = 0;
        while (!complete && n < 200) begin
            if (noise) begin
                result_ack = $urandom_range(0, 1);
                div_valid  = $urandom_range(0, 1);
                x          = $urandom;
                y          = $urandom;
            end
            @(posedge mul_clk); #1;
            n++;
        end
        result_ack = 1'b0;
        div_valid  = 1'b0;
        if (sbQ.size() == 0) begin
            checkVal("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            lastExp = sbQ.pop_front();
            checkVal("latency", 32'(n), 32'(lastExp.lat));
            checkVal("quotient", s, lastExp.s);
            checkVal("remainder", r, lastExp.r);
        end
    endtask

    task automatic ackIt();
        result_ack = 1'b1;
        @(posedge mul_clk); #1;
        result_ack = 1'b0;
        checkVal("complete_after_ack", 32'(complete), 32'd0);
        checkVal("ready_after_ack", 32'(div_ready), 32'd1);
    endtask

    task automatic runOne(input logic sgn, input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] es, input logic [31:0] er, input bit noise);
        exp_t e;
        e.s   = es;
        e.r   = er;
        e.lat = (yv == 32'd0) ? zeroLat() : 34;
        issue(sgn, xv, yv, e);
        waitDone(noise);
        $display("div sgn=%0d x=%h y=%h -> s=%h r=%h", sgn, xv, yv, s, r);
        ackIt();
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] xv, yv, es, er;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int cHigh;
        int ackCycle;
        exp_t e;
        logic sgn;
        logic [31:0] xv, yv;

        resetn = 1'b0; div_valid = 1'b0; div_signed = 1'b0; result_ack = 1'b0;
        x = 32'd0; y = 32'd0;
        repeat (2) @(posedge mul_clk);
        #1;
        checkVal("reset_ready", 32'(div_ready), 32'd1);
        checkVal("reset_complete", 32'(complete), 32'd0);
        checkVal("reset_s", s, 32'd0);
        checkVal("reset_r", r, 32'd0);
        resetn = 1'b1;

        // unsigned 100/7 with a 5-cycle hold before ack
        e.s = 32'd14; e.r = 32'd2; e.lat = 34;
        issue(1'b0, 32'd100, 32'd7, e);
        waitDone(1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge mul_clk); #1;
            checkVal("hold_complete", 32'(complete), 32'd1);
            checkVal("hold_s", s, 32'd14);
            checkVal("hold_r", r, 32'd2);
        end
        $display("div sgn=0 x=%h y=%h -> s=%h r=%h", 32'd100, 32'd7, s, r);
        ackIt();

        vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        vecs[1] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0};
        vecs[4] = '{1'b0, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5};
        vecs[5] = '{1'b1, 32'hFFFF_FFFB, 32'd0,        32'd1,         32'hFFFF_FFFB};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'd1,        32'd0};
        vecs[7] = '{1'b1, 32'h8000_0000, 32'd0,        32'd1,         32'h8000_0000};
        foreach (vecs[i])
            runOne(vecs[i].sgn, vecs[i].xv, vecs[i].yv, vecs[i].es, vecs[i].er, 1'b0);

        // reset in the middle of ITER discards the operation
        e.s = 32'd14; e.r = 32'd2; e.lat = 34;
        issue(1'b0, 32'd100, 32'd7, e);
        repeat (11) @(posedge mul_clk);
        #1;
        resetn     = 1'b0;
        result_ack = 1'b1;
        div_valid  = 1'b1;
        @(posedge mul_clk); #1;
        resetn     = 1'b1;
        result_ack = 1'b0;
        div_valid  = 1'b0;
        sbQ.delete();
        haveLast = 0;
        checkVal("midreset_ready", 32'(div_ready), 32'd1);
        checkVal("midreset_complete", 32'(complete), 32'd0);
        checkVal("midreset_s", s, 32'd0);
        checkVal("midreset_r", r, 32'd0);
        cHigh = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge mul_clk); #1;
            if (complete) cHigh++;
        end
        checkVal("midreset_no_complete", 32'(cHigh), 32'd0);
        runOne(1'b1, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 32'd6, 1'b0);

        // ack and new request in the same cycle: accepted one cycle later
        e.s = 32'd100; e.r = 32'd0; e.lat = 34;
        issue(1'b0, 32'd1000, 32'd10, e);
        waitDone(1'b0);
        result_ack = 1'b1;
        div_valid  = 1'b1;
        div_signed = 1'b0;
        x = 32'd77; y = 32'd5;
        @(posedge mul_clk); #1;
        ackCycle   = cycleCnt;
        result_ack = 1'b0;
        checkVal("b2b_complete_low", 32'(complete), 32'd0);
        checkVal("b2b_ready_high", 32'(div_ready), 32'd1);
        e.s = 32'd15; e.r = 32'd2; e.lat = 34;
        issue(1'b0, 32'd77, 32'd5, e);
        checkVal("b2b_accept_delay", 32'(cycleCnt - ackCycle), 32'd1);
        waitDone(1'b0);
        ackIt();

        // random pairs with ignored ack/valid noise while busy
        for (int i = 0; i < 150; i++) begin
            sgn = $urandom_range(0, 1);
            xv  = $urandom;
            case ($urandom_range(0, 4))
                0: yv = $urandom_range(0, 15);
                1: yv = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                2: yv = $urandom & 32'h0000_FFFF;
                default: yv = $urandom;
            endcase
            e = model(sgn, xv, yv);
            runOne(sgn, xv, yv, e.s, e.r, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
